// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C slave register bank:
//   state_t             FSM state encoding (4-bit)
//   I2C_ACK / I2C_NACK  bus level of the acknowledge bit
//   RW_WRITE / RW_READ  value of the R/W bit in the address byte
// ----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WR        = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD        = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// ----------------------------------------------------------------------------
// i2c_line_sync
// Brings the asynchronous SCL/SDA pins into the clk domain and derives the
// bus events used by the slave FSM.
//   clk, reset      system clock, async active-low reset
//   scl_in, sda_in  raw bus pins
//   sda_lvl         cleaned SDA level (aligned with the event pulses)
//   scl_rise/fall   1-cycle pulses on cleaned SCL edges
//   start_det       SDA falling while SCL high
//   stop_det        SDA rising while SCL high
// Build option: I2C_GLITCH_FILTER_EN adds a 3-sample filter after each sync
// chain; without it the 2-FF synchroniser output is used directly.
// ----------------------------------------------------------------------------
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // Idle bus is high, so every stage resets to 1 to avoid phantom edges.
  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic       w_scl_clean;
  logic       w_sda_clean;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  // The output only moves once three consecutive samples agree, so any
  // pulse shorter than 3 clk never reaches the FSM.
  logic [1:0] r_scl_hist;
  logic [1:0] r_sda_hist;
  logic       r_scl_filt;
  logic       r_sda_filt;
  logic [2:0] w_scl_win;
  logic [2:0] w_sda_win;

  assign w_scl_win = {r_scl_hist, r_scl_sync[1]};
  assign w_sda_win = {r_sda_hist, r_sda_sync[1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      if (&w_scl_win)       r_scl_filt <= 1'b1;
      else if (~|w_scl_win) r_scl_filt <= 1'b0;
      if (&w_sda_win)       r_sda_filt <= 1'b1;
      else if (~|w_sda_win) r_sda_filt <= 1'b0;
    end
  end

  assign w_scl_clean = r_scl_filt;
  assign w_sda_clean = r_sda_filt;
`else
  assign w_scl_clean = r_scl_sync[1];
  assign w_sda_clean = r_sda_sync[1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl_clean;
      r_sda_prev <= w_sda_clean;
    end
  end

  assign sda_lvl   = w_sda_clean;
  assign scl_rise  =  w_scl_clean & ~r_scl_prev;
  assign scl_fall  = ~w_scl_clean &  r_scl_prev;
  // SCL must be high on both samples so an SDA change next to an SCL edge
  // is never mistaken for START/STOP.
  assign start_det = w_scl_clean & r_scl_prev &  r_sda_prev & ~w_sda_clean;
  assign stop_det  = w_scl_clean & r_scl_prev & ~r_sda_prev &  w_sda_clean;

endmodule

// File: rtl/i2c_slave_regbank.sv
// ----------------------------------------------------------------------------
// i2c_slave_regbank
// I2C slave (7-bit address SLAVE_ADDR) in front of a DEPTH x 8 register bank.
// Burst write/read with pointer auto-increment (wrapping at DEPTH-1),
// repeated START, NACK on address mismatch or out-of-range pointer.
// Ports:
//   clk, reset             100 MHz system clock, async active-low reset
//   scl, sda               I2C bus (sda open-drain: 0 or z only)
//   host_addr/host_rdata   combinational user readback of the bank
//   wr_strobe/addr/data    1-cycle notification of each committed write
//   start, stop            1-cycle bus condition pulses
//   busy                   addressed transfer in progress (until STOP)
//   ack_error              sticky: master kept clocking after a read NACK
// Build option: I2C_GLITCH_FILTER_EN (see i2c_line_sync).
//
// state        | meaning
// -------------+------------------------------------------------------
// IDLE         | bus free or not for us, wait for START
// ADDR         | shift in address + R/W
// ADDR_ACK     | drive ACK for the address; then go to PTR or RD
// PTR          | shift in register pointer
// PTR_ACK      | drive ACK for the pointer
// WR           | shift in a data byte, commit on 8th bit
// WR_ACK       | drive ACK for the data byte
// RD           | drive data byte MSB first
// RD_ACK       | release SDA, sample master ACK/NACK
// WAIT_STOP    | ignore the bus until START/STOP
// ----------------------------------------------------------------------------
module i2c_slave_regbank
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h6A,
  parameter int         DEPTH      = 16,
  parameter int         PTR_W      = 4,
  parameter logic [7:0] RST_VAL    = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl,
  inout  wire              sda,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             start,
  output logic             stop,
  output logic             busy,
  output logic             ack_error
);

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start_det;
  logic w_stop_det;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl),
    .sda_in    (sda),
    .sda_lvl   (w_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start_det),
    .stop_det  (w_stop_det)
  );

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitcnt;
  logic [PTR_W-1:0] r_ptr;
  logic [7:0]       r_regs [DEPTH];
  logic             r_sda_low;
  logic             r_ack_phase;  // ACK slot: 0 = before its SCL low, 1 = inside it
  logic             r_rw;
  logic             r_mack;       // master's answer in RD_ACK
  logic             r_rd_nack;    // WAIT_STOP entered via a read NACK
  logic             r_wr_strobe;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_start;
  logic             r_stop;
  logic             r_busy;
  logic             r_ack_error;

  logic [7:0]       w_byte;
  logic [PTR_W-1:0] w_ptr_next;
  logic [2:0]       w_rd_idx;

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_ptr_next = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
  // r_bitcnt counts bits already clocked out, so the next one is 7-count.
  assign w_rd_idx   = 3'd7 - r_bitcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_ptr       <= '0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= RST_VAL;
      r_sda_low   <= 1'b0;
      r_ack_phase <= 1'b0;
      r_rw        <= RW_WRITE;
      r_mack      <= I2C_NACK;
      r_rd_nack   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      r_busy      <= 1'b0;
      r_ack_error <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      if (w_stop_det) begin
        r_state     <= ST_IDLE;
        r_sda_low   <= 1'b0;
        r_ack_phase <= 1'b0;
        r_rd_nack   <= 1'b0;
        r_stop      <= 1'b1;
        r_busy      <= 1'b0;
      end else if (w_start_det) begin
        // Repeated START keeps r_ptr so pointer-write + Sr + read works.
        r_state     <= ST_ADDR;
        r_bitcnt    <= '0;
        r_sda_low   <= 1'b0;
        r_ack_phase <= 1'b0;
        r_rd_nack   <= 1'b0;
        r_start     <= 1'b1;
        r_ack_error <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
          end

          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  r_rw    <= w_byte[0];
                  r_busy  <= 1'b1;
                  r_state <= ST_ADDR_ACK;
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_low   <= ~I2C_ACK;
                r_ack_phase <= 1'b1;
              end else begin
                r_ack_phase <= 1'b0;
                r_bitcnt    <= '0;
                if (r_rw == RW_WRITE) begin
                  r_sda_low <= 1'b0;
                  r_state   <= ST_PTR;
                end else begin
                  r_shift   <= r_regs[r_ptr];
                  r_sda_low <= ~r_regs[r_ptr][7];
                  r_state   <= ST_RD;
                end
              end
            end
          end

          ST_PTR: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                if (32'(w_byte) < DEPTH) begin
                  r_ptr   <= w_byte[PTR_W-1:0];
                  r_state <= ST_PTR_ACK;
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end
            end
          end

          ST_PTR_ACK, ST_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_low   <= ~I2C_ACK;
                r_ack_phase <= 1'b1;
              end else begin
                r_sda_low   <= 1'b0;
                r_ack_phase <= 1'b0;
                r_bitcnt    <= '0;
                r_state     <= ST_WR;
              end
            end
          end

          ST_WR: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_regs[r_ptr] <= w_byte;
                r_wr_strobe   <= 1'b1;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_byte;
                r_ptr         <= w_ptr_next;
                r_state       <= ST_WR_ACK;
              end
            end
          end

          ST_RD: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_ack_phase <= 1'b0;
                r_state     <= ST_RD_ACK;
              end
            end else if (w_scl_fall) begin
              r_sda_low <= ~r_shift[w_rd_idx];
            end
          end

          ST_RD_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_phase) begin
                r_sda_low   <= 1'b0;
                r_ack_phase <= 1'b1;
              end else begin
                r_ack_phase <= 1'b0;
                r_bitcnt    <= '0;
                if (r_mack == I2C_ACK) begin
                  r_shift   <= r_regs[r_ptr];
                  r_sda_low <= ~r_regs[r_ptr][7];
                  r_state   <= ST_RD;
                end else begin
                  r_rd_nack <= 1'b1;
                  r_state   <= ST_WAIT_STOP;
                end
              end
            end else if (w_scl_rise && r_ack_phase) begin
              r_mack <= w_sda;
              if (w_sda == I2C_ACK) r_ptr <= w_ptr_next;
            end
          end

          ST_WAIT_STOP: begin
            // A full SCL pulse after a read NACK means the master did not
            // accept the end of the read; the STOP itself has no SCL fall.
            if (w_scl_fall && r_rd_nack) r_ack_error <= 1'b1;
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign sda        = r_sda_low ? 1'b0 : 1'bz;
  assign host_rdata = (32'(host_addr) < DEPTH) ? r_regs[host_addr] : RST_VAL;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign start      = r_start;
  assign stop       = r_stop;
  assign busy       = r_busy;
  assign ack_error  = r_ack_error;

endmodule
